// File: rtl/risc_pkg.sv
// Opcode map, instruction field layout and decode helpers shared by the
// decode stage and the execution unit.
package risc_pkg;

    localparam int INSTR_W  = 16;
    localparam int DATA_W   = 8;
    localparam int RADDR_W  = 3;
    localparam int OP_W     = 4;
    localparam int DMADDR_W = 4;

    localparam int OP_LSB     = 12;
    localparam int DST_LSB    = 9;
    localparam int SRCA_LSB   = 6;
    localparam int SRCB_LSB   = 3;
    localparam int DMADDR_LSB = 0;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_AND = 4'h3;
    localparam logic [OP_W-1:0] OP_OR  = 4'h4;
    localparam logic [OP_W-1:0] OP_XOR = 4'h5;
    localparam logic [OP_W-1:0] OP_SHR = 4'h6;
    localparam logic [OP_W-1:0] OP_SHL = 4'h7;
    localparam logic [OP_W-1:0] OP_ROR = 4'h8;
    localparam logic [OP_W-1:0] OP_ROL = 4'h9;
    localparam logic [OP_W-1:0] OP_NOT = 4'hA;
    localparam logic [OP_W-1:0] OP_MOV = 4'hB;
    localparam logic [OP_W-1:0] OP_INC = 4'hC;
    localparam logic [OP_W-1:0] OP_DEC = 4'hD;
    localparam logic [OP_W-1:0] OP_LD  = 4'hE;
    localparam logic [OP_W-1:0] OP_ST  = 4'hF;

    // Contents of the decode output register stage handed to execute.
    typedef struct packed {
        logic [OP_W-1:0]     opcode;
        logic [RADDR_W-1:0]  dst;
        logic [DMADDR_W-1:0] dmaddr;
        logic [DATA_W-1:0]   oprnd_a;
        logic [DATA_W-1:0]   oprnd_b;
    } issue_t;

    function automatic logic uses_src_a(input logic [OP_W-1:0] op);
        return (op != OP_NOP) && (op != OP_LD);
    endfunction

    function automatic logic uses_src_b(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_ROL);
    endfunction

    function automatic logic is_reg_write(input logic [OP_W-1:0] op);
        return (op != OP_NOP) && (op != OP_ST);
    endfunction

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/risc_decode_if.sv
// Decode-stage bus: fetch handshake, EX/WB forwarding inputs and the
// registered issue outputs towards the execution unit.
interface risc_decode_if;
    import risc_pkg::*;

    logic [INSTR_W-1:0]  instr;
    logic                instr_vld;
    logic                instr_rdy;
    logic                wb_en;
    logic [RADDR_W-1:0]  wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic [DATA_W-1:0]   ex_rslt;
    logic [RADDR_W-1:0]  ex_dst;
    logic                ex_reg_wr_vld;
    logic                ex_load_op;
    logic [OP_W-1:0]     opcode;
    logic [DMADDR_W-1:0] dmaddr;
    logic [DATA_W-1:0]   oprnd_a;
    logic [DATA_W-1:0]   oprnd_b;
    logic [RADDR_W-1:0]  dst;

    modport master (
        output instr, instr_vld, wb_en, wb_addr, wb_data,
               ex_rslt, ex_dst, ex_reg_wr_vld, ex_load_op,
        input  instr_rdy, opcode, dmaddr, oprnd_a, oprnd_b, dst
    );

    modport slave (
        input  instr, instr_vld, wb_en, wb_addr, wb_data,
               ex_rslt, ex_dst, ex_reg_wr_vld, ex_load_op,
        output instr_rdy, opcode, dmaddr, oprnd_a, oprnd_b, dst
    );

endinterface

// File: rtl/risc_regfile.sv
// General-purpose register file: one synchronous write port, two
// combinational read ports, cleared by reset.
module risc_regfile
    import risc_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [RADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic [RADDR_W-1:0] i_raddr_a,
    input  logic [RADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0]  o_rdata_a,
    output logic [DATA_W-1:0]  o_rdata_b
);

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/risc_decode.sv
// Decode stage: scoreboard, hazard detection, EX/WB operand forwarding and
// a single output register stage feeding the execution unit.
module risc_decode
    import risc_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int IW    = 16
) (
    input  logic         clk,
    input  logic         rst,
    risc_decode_if.slave bus
);

    logic [IW-1:0]      w_instr;
    logic [OP_W-1:0]    w_op;
    logic [RADDR_W-1:0] w_dst;
    logic [RADDR_W-1:0] w_src   [2];
    logic               w_used  [2];
    logic [DATA_W-1:0]  w_rf_rd [2];
    logic [DATA_W-1:0]  w_opnd  [2];
    logic               w_hold  [2];
    logic               w_held_wr;
    logic               w_stall;
    logic               w_issue;

    issue_t             r_out;
    issue_t             w_out_next;
    logic [NREGS-1:0]   r_pend;
    logic [NREGS-1:0]   w_pend_next;
    logic [NREGS-1:0]   w_pend_set;
    logic [NREGS-1:0]   w_pend_clr;

    assign w_instr   = bus.instr;
    assign w_op      = w_instr[OP_LSB +: OP_W];
    assign w_dst     = w_instr[DST_LSB +: RADDR_W];
    assign w_src[0]  = w_instr[SRCA_LSB +: RADDR_W];
    assign w_src[1]  = w_instr[SRCB_LSB +: RADDR_W];
    assign w_used[0] = uses_src_a(w_op);
    assign w_used[1] = uses_src_b(w_op);

    // The instruction sitting in the output registers has not produced its
    // result anywhere yet, so nothing can be forwarded from it.
    assign w_held_wr = is_reg_write(r_out.opcode);

    risc_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (bus.wb_en),
        .i_waddr   (bus.wb_addr),
        .i_wdata   (bus.wb_data),
        .i_raddr_a (w_src[0]),
        .i_raddr_b (w_src[1]),
        .o_rdata_a (w_rf_rd[0]),
        .o_rdata_b (w_rf_rd[1])
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] w_val;
            logic              w_hz;

            // Source priority: held result, EX forward, WB bypass, pending, regfile.
            always_comb begin
                w_val = w_rf_rd[gi];
                w_hz  = 1'b0;
                if (w_held_wr && (r_out.dst == w_src[gi])) begin
                    w_hz = 1'b1;
                end else if (bus.ex_reg_wr_vld && !bus.ex_load_op &&
                             (bus.ex_dst == w_src[gi])) begin
                    w_val = bus.ex_rslt;
                end else if (bus.wb_en && (bus.wb_addr == w_src[gi])) begin
                    w_val = bus.wb_data;
                end else if (r_pend[w_src[gi]]) begin
                    w_hz = 1'b1;
                end
            end

            assign w_opnd[gi] = w_val;
            assign w_hold[gi] = w_used[gi] && w_hz;
        end
    endgenerate

    assign w_stall       = w_hold[0] || w_hold[1];
    assign w_issue       = bus.instr_vld && !w_stall;
    assign bus.instr_rdy = !w_stall;

    always_comb begin
        w_out_next        = '0;
        w_out_next.opcode = OP_NOP;
        if (w_issue) begin
            w_out_next.opcode  = w_op;
            w_out_next.dst     = w_dst;
            w_out_next.dmaddr  = is_mem_op(w_op) ? w_instr[DMADDR_LSB +: DMADDR_W] : '0;
            w_out_next.oprnd_a = w_used[0] ? w_opnd[0] : '0;
            w_out_next.oprnd_b = w_used[1] ? w_opnd[1] : '0;
        end
    end

    // Set is applied after clear so an issue to a register being written back
    // in the same cycle leaves the bit pending.
    always_comb begin
        w_pend_set = '0;
        w_pend_clr = '0;
        if (bus.wb_en) begin
            w_pend_clr[bus.wb_addr] = 1'b1;
        end
        if (w_issue && is_reg_write(w_op)) begin
            w_pend_set[w_dst] = 1'b1;
        end
        w_pend_next = (r_pend & ~w_pend_clr) | w_pend_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_pend <= '0;
        end else begin
            r_out  <= w_out_next;
            r_pend <= w_pend_next;
        end
    end

    assign bus.opcode  = r_out.opcode;
    assign bus.dst     = r_out.dst;
    assign bus.dmaddr  = r_out.dmaddr;
    assign bus.oprnd_a = r_out.oprnd_a;
    assign bus.oprnd_b = r_out.oprnd_b;

endmodule

// File: tb/tb_risc_decode.sv
// Bench for risc_decode: directed pipeline scenarios plus randomized traffic
// checked against a table-driven architectural model.
module tb_risc_decode;
    import risc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    risc_decode_if bus();

    risc_decode #(.NREGS(8), .IW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_cyc   = 0;

    // Per-opcode property tables, bit index = opcode value.
    logic [15:0] tbl_uses_a = 16'hBFFE;
    logic [15:0] tbl_uses_b = 16'h03FE;
    logic [15:0] tbl_writes = 16'h7FFE;
    logic [15:0] tbl_mem    = 16'hC000;

    logic [7:0] m_regs [8];
    bit         m_pend [8];
    logic [3:0] m_op;
    logic [2:0] m_dst;
    logic [3:0] m_dm;
    logic [7:0] m_a, m_b;
    logic       m_rdy;
    logic       obs_rdy;

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] d,
                                       input logic [2:0] a, input logic [2:0] b);
        return {op, d, a, b, 3'b000};
    endfunction

    function automatic logic [15:0] mkmem(input logic [3:0] op, input logic [2:0] d,
                                          input logic [2:0] a, input logic [3:0] dm);
        return {op, d, a, 2'b00, dm};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 8'h00;
            m_pend[i] = 1'b0;
        end
        m_op = 4'h0; m_dst = 3'd0; m_dm = 4'h0; m_a = 8'h00; m_b = 8'h00;
    endtask

    function automatic void m_source(input logic [2:0] s, output bit stall, output logic [7:0] val);
        stall = 1'b0;
        val   = m_regs[s];
        if (tbl_writes[m_op] && m_dst == s) stall = 1'b1;
        else if (bus.ex_reg_wr_vld && !bus.ex_load_op && bus.ex_dst == s) val = bus.ex_rslt;
        else if (bus.wb_en && bus.wb_addr == s) val = bus.wb_data;
        else if (m_pend[s]) stall = 1'b1;
    endfunction

    task automatic drive(input logic [15:0] ins, input logic vld, input logic wbe,
                         input logic [2:0] wba, input logic [7:0] wbd, input logic exv,
                         input logic exl, input logic [2:0] exd, input logic [7:0] exr);
        bus.instr = ins; bus.instr_vld = vld;
        bus.wb_en = wbe; bus.wb_addr = wba; bus.wb_data = wbd;
        bus.ex_reg_wr_vld = exv; bus.ex_load_op = exl; bus.ex_dst = exd; bus.ex_rslt = exr;
    endtask

    // One clock: drive at negedge, sample ready before the edge, outputs after it.
    task automatic cycle(input logic [15:0] ins, input logic vld, input logic wbe,
                         input logic [2:0] wba, input logic [7:0] wbd, input logic exv,
                         input logic exl, input logic [2:0] exd, input logic [7:0] exr);
        bit sa, sb, issue;
        logic [7:0] va, vb;
        logic [3:0] op;
        @(negedge clk);
        drive(ins, vld, wbe, wba, wbd, exv, exl, exd, exr);
        #1;
        op = ins[15:12];
        m_source(ins[8:6], sa, va);
        m_source(ins[5:3], sb, vb);
        m_rdy   = !((tbl_uses_a[op] && sa) || (tbl_uses_b[op] && sb));
        obs_rdy = bus.instr_rdy;
        issue   = vld && m_rdy;
        @(posedge clk);
        if (wbe) begin
            m_regs[wba] = wbd;
            m_pend[wba] = 1'b0;
        end
        if (issue) begin
            m_op  = op;
            m_dst = ins[11:9];
            m_dm  = tbl_mem[op] ? ins[3:0] : 4'h0;
            m_a   = tbl_uses_a[op] ? va : 8'h00;
            m_b   = tbl_uses_b[op] ? vb : 8'h00;
            if (tbl_writes[op]) m_pend[ins[11:9]] = 1'b1;
        end else begin
            m_op = 4'h0; m_dst = 3'd0; m_dm = 4'h0; m_a = 8'h00; m_b = 8'h00;
        end
        #1;
        n_cyc++;
        $display("cyc %0d instr=%h vld=%b rdy=%b -> op=%h dst=%0d dm=%h a=%h b=%h",
                 n_cyc, ins, vld, obs_rdy, bus.opcode, bus.dst, bus.dmaddr, bus.oprnd_a, bus.oprnd_b);
    endtask

    task automatic wb(input logic [2:0] a, input logic [7:0] d);
        cycle(16'h0000, 1'b0, 1'b1, a, d, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic test_reset();
        drive(16'h0000, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (bus.opcode !== 4'h0) $display("FAIL reset_opcode got=%h exp=0", bus.opcode); else n_pass++;
        n_total++; if (bus.dst !== 3'd0) $display("FAIL reset_dst got=%0d exp=0", bus.dst); else n_pass++;
        n_total++; if (bus.dmaddr !== 4'h0) $display("FAIL reset_dmaddr got=%h exp=0", bus.dmaddr); else n_pass++;
        n_total++; if (bus.oprnd_a !== 8'h00 || bus.oprnd_b !== 8'h00)
            $display("FAIL reset_oprnd got=%h/%h exp=00/00", bus.oprnd_a, bus.oprnd_b); else n_pass++;
        n_total++; if (bus.instr_rdy !== 1'b1) $display("FAIL reset_rdy got=%b exp=1", bus.instr_rdy); else n_pass++;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_add();
        wb(3'd1, 8'h05);
        wb(3'd2, 8'h07);
        cycle(mk(OP_ADD, 3'd3, 3'd1, 3'd2), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        n_total++; if (obs_rdy !== 1'b1) $display("FAIL add_rdy got=%b exp=1", obs_rdy); else n_pass++;
        n_total++; if (bus.opcode !== 4'b0001) $display("FAIL add_opcode got=%h exp=1", bus.opcode); else n_pass++;
        n_total++; if (bus.oprnd_a !== 8'h05) $display("FAIL add_oprnd_a got=%h exp=05", bus.oprnd_a); else n_pass++;
        n_total++; if (bus.oprnd_b !== 8'h07) $display("FAIL add_oprnd_b got=%h exp=07", bus.oprnd_b); else n_pass++;
        n_total++; if (bus.dst !== 3'd3 || bus.dmaddr !== 4'h0)
            $display("FAIL add_dst_dm got=%0d/%h exp=3/0", bus.dst, bus.dmaddr); else n_pass++;
        wb(3'd3, 8'h0C);
    endtask

    task automatic test_back_to_back();
        cycle(mk(OP_ADD, 3'd1, 3'd2, 3'd2), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        n_total++; if (bus.opcode !== OP_ADD || bus.oprnd_a !== 8'h07 || bus.oprnd_b !== 8'h07)
            $display("FAIL b2b_first got=%h %h %h exp=1 07 07", bus.opcode, bus.oprnd_a, bus.oprnd_b); else n_pass++;
        cycle(mk(OP_SUB, 3'd4, 3'd1, 3'd2), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        n_total++; if (obs_rdy !== 1'b0) $display("FAIL b2b_stall_rdy got=%b exp=0", obs_rdy); else n_pass++;
        n_total++; if (bus.opcode !== OP_NOP || bus.dst !== 3'd0 || bus.oprnd_a !== 8'h00)
            $display("FAIL b2b_bubble got=%h %0d %h exp=0 0 00", bus.opcode, bus.dst, bus.oprnd_a); else n_pass++;
        cycle(mk(OP_SUB, 3'd4, 3'd1, 3'd2), 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h0E);
        n_total++; if (obs_rdy !== 1'b1) $display("FAIL b2b_fwd_rdy got=%b exp=1", obs_rdy); else n_pass++;
        n_total++; if (bus.opcode !== OP_SUB || bus.dst !== 3'd4)
            $display("FAIL b2b_fwd_op got=%h/%0d exp=2/4", bus.opcode, bus.dst); else n_pass++;
        n_total++; if (bus.oprnd_a !== 8'h0E || bus.oprnd_b !== 8'h07)
            $display("FAIL b2b_fwd_oprnd got=%h/%h exp=0e/07", bus.oprnd_a, bus.oprnd_b); else n_pass++;
        wb(3'd1, 8'h0E);
        wb(3'd4, 8'h07);
    endtask

    task automatic test_load();
        cycle(mkmem(OP_LD, 3'd2, 3'd0, 4'hA), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        n_total++; if (bus.opcode !== OP_LD || bus.dmaddr !== 4'hA || bus.dst !== 3'd2)
            $display("FAIL ld_issue got=%h %h %0d exp=e a 2", bus.opcode, bus.dmaddr, bus.dst); else n_pass++;
        cycle(mk(OP_ADD, 3'd5, 3'd2, 3'd2), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        n_total++; if (obs_rdy !== 1'b0 || bus.opcode !== OP_NOP)
            $display("FAIL ld_stall1 got rdy=%b op=%h exp rdy=0 op=0", obs_rdy, bus.opcode); else n_pass++;
        cycle(mk(OP_ADD, 3'd5, 3'd2, 3'd2), 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd2, 8'h55);
        n_total++; if (obs_rdy !== 1'b0 || bus.opcode !== OP_NOP)
            $display("FAIL ld_stall2 got rdy=%b op=%h exp rdy=0 op=0", obs_rdy, bus.opcode); else n_pass++;
        cycle(mk(OP_ADD, 3'd5, 3'd2, 3'd2), 1'b1, 1'b1, 3'd2, 8'h3C, 1'b0, 1'b0, 3'd0, 8'h00);
        n_total++; if (obs_rdy !== 1'b1) $display("FAIL ld_wb_rdy got=%b exp=1", obs_rdy); else n_pass++;
        n_total++; if (bus.opcode !== OP_ADD || bus.dst !== 3'd5 || bus.oprnd_a !== 8'h3C || bus.oprnd_b !== 8'h3C)
            $display("FAIL ld_wb_issue got=%h %0d %h %h exp=1 5 3c 3c", bus.opcode, bus.dst, bus.oprnd_a, bus.oprnd_b);
        else n_pass++;
        wb(3'd5, 8'h78);
    endtask

    task automatic test_store();
        wb(3'd6, 8'h81);
        cycle(mkmem(OP_ST, 3'd6, 3'd6, 4'h4), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        n_total++; if (bus.opcode !== 4'b1111 || bus.dmaddr !== 4'h4)
            $display("FAIL st_op_dm got=%h/%h exp=f/4", bus.opcode, bus.dmaddr); else n_pass++;
        n_total++; if (bus.oprnd_a !== 8'h81 || bus.oprnd_b !== 8'h00)
            $display("FAIL st_oprnd got=%h/%h exp=81/00", bus.oprnd_a, bus.oprnd_b); else n_pass++;
        cycle(mk(OP_ADD, 3'd7, 3'd6, 3'd6), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        n_total++; if (obs_rdy !== 1'b1 || bus.oprnd_a !== 8'h81)
            $display("FAIL st_no_pend got rdy=%b a=%h exp rdy=1 a=81", obs_rdy, bus.oprnd_a); else n_pass++;
        wb(3'd7, 8'h02);
    endtask

    task automatic test_wb_bypass();
        cycle(mk(OP_MOV, 3'd0, 3'd1, 3'd0), 1'b1, 1'b1, 3'd1, 8'h22, 1'b0, 1'b0, 3'd0, 8'h00);
        n_total++; if (obs_rdy !== 1'b1) $display("FAIL byp_rdy got=%b exp=1", obs_rdy); else n_pass++;
        n_total++; if (bus.opcode !== OP_MOV || bus.oprnd_a !== 8'h22 || bus.oprnd_b !== 8'h00)
            $display("FAIL byp_oprnd got=%h %h %h exp=b 22 00", bus.opcode, bus.oprnd_a, bus.oprnd_b); else n_pass++;
        wb(3'd0, 8'h22);
    endtask

    task automatic test_set_wins();
        cycle(mk(OP_ADD, 3'd5, 3'd0, 3'd0), 1'b1, 1'b1, 3'd5, 8'h11, 1'b0, 1'b0, 3'd0, 8'h00);
        cycle(16'h0000, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        cycle(mk(OP_MOV, 3'd6, 3'd5, 3'd0), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        n_total++; if (obs_rdy !== 1'b0) $display("FAIL set_wins_rdy got=%b exp=0", obs_rdy); else n_pass++;
        wb(3'd5, 8'h11);
    endtask

    task automatic test_reset_mid_stall();
        cycle(mk(OP_ADD, 3'd1, 3'd2, 3'd2), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        drive(mk(OP_SUB, 3'd4, 3'd1, 3'd2), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        #1;
        n_total++; if (bus.instr_rdy !== 1'b0) $display("FAIL rst_stall_rdy got=%b exp=0", bus.instr_rdy); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++; if (bus.opcode !== 4'h0 || bus.dst !== 3'd0 || bus.dmaddr !== 4'h0 ||
                       bus.oprnd_a !== 8'h00 || bus.oprnd_b !== 8'h00)
            $display("FAIL rst_async_outs got=%h %0d %h %h %h exp=all 0",
                     bus.opcode, bus.dst, bus.dmaddr, bus.oprnd_a, bus.oprnd_b);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.instr_vld = 1'b0;
        m_reset();
        #1;
        n_total++; if (bus.instr_rdy !== 1'b1) $display("FAIL rst_release_rdy got=%b exp=1", bus.instr_rdy); else n_pass++;
        cycle(mk(OP_SUB, 3'd4, 3'd1, 3'd2), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        n_total++; if (bus.opcode !== OP_SUB || bus.dst !== 3'd4 || bus.oprnd_a !== 8'h00 || bus.oprnd_b !== 8'h00)
            $display("FAIL rst_reissue got=%h %0d %h %h exp=2 4 00 00", bus.opcode, bus.dst, bus.oprnd_a, bus.oprnd_b);
        else n_pass++;
        wb(3'd4, 8'h00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle(16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                  3'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 8'($urandom));
            n_total++; if (obs_rdy !== m_rdy) $display("FAIL rand_rdy i=%0d got=%b exp=%b", i, obs_rdy, m_rdy); else n_pass++;
            n_total++; if (bus.opcode !== m_op) $display("FAIL rand_opcode i=%0d got=%h exp=%h", i, bus.opcode, m_op); else n_pass++;
            n_total++; if (bus.dst !== m_dst) $display("FAIL rand_dst i=%0d got=%0d exp=%0d", i, bus.dst, m_dst); else n_pass++;
            n_total++; if (bus.dmaddr !== m_dm) $display("FAIL rand_dmaddr i=%0d got=%h exp=%h", i, bus.dmaddr, m_dm); else n_pass++;
            n_total++; if (bus.oprnd_a !== m_a) $display("FAIL rand_oprnd_a i=%0d got=%h exp=%h", i, bus.oprnd_a, m_a); else n_pass++;
            n_total++; if (bus.oprnd_b !== m_b) $display("FAIL rand_oprnd_b i=%0d got=%h exp=%h", i, bus.oprnd_b, m_b); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        m_reset();
        test_reset();
        test_add();
        test_back_to_back();
        test_load();
        test_store();
        test_wb_bypass();
        test_set_wins();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/risc_decode.md
RISC_DECODE -- requirements
Module: risc_decode

Interface
REQ-001 Parameter: NREGS, 8, register-file depth; fixed at 8 for the 3-bit register fields.
REQ-002 Parameter: IW, 16, instruction width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 instr  input  16  instruction word from fetch.
REQ-006 instr_vld  input  1  instr is valid this cycle.
REQ-007 instr_rdy  output  1  decode accepts instr this cycle.
REQ-008 wb_en  input  1  register write-back strobe from the write-back stage.
REQ-009 wb_addr  input  3  write-back register address.
REQ-010 wb_data  input  8  write-back data (ALU result or load data).
REQ-011 ex_rslt  input  8  registered result from the execution unit.
REQ-012 ex_dst  input  3  destination of ex_rslt.
REQ-013 ex_reg_wr_vld  input  1  ex_rslt targets a register.
REQ-014 ex_load_op  input  1  execution-stage instruction is ld; ex_rslt is not the load data.
REQ-015 opcode  output  4  registered opcode to the execution unit.
REQ-016 dmaddr  output  4  registered data-memory address.
REQ-017 oprnd_a, oprnd_b  output  8 each  registered operands.
REQ-018 dst  output  3  registered destination register.

Function
REQ-019 Instruction fields SHALL be: [15:12] opcode, [11:9] dst, [8:6] src_a, [5:3] src_b, [3:0] dmaddr (ld/st only).
REQ-020 src_a SHALL be used by every opcode except nop and ld; src_b SHALL be used only by add, sub, and, or, xor, shr, shl, ror and rol.
REQ-021 A register write instruction SHALL be any opcode other than nop and st.
REQ-022 An instruction SHALL be issued on the rising edge where instr_vld && instr_rdy; outputs SHALL update one cycle after acceptance (latency 1).
REQ-023 When instr_vld is low or the decoder is stalled, the next registered outputs SHALL be a bubble: opcode=nop, dst=0, dmaddr=0, operands=0.
REQ-024 Scoreboard: 8-bit pending vector; the bit for dst SHALL be set on issue of a register write instruction and cleared on wb_en for wb_addr.
REQ-025 If a set and a clear of the same scoreboard bit occur in the same cycle, the set SHALL win.
REQ-026 The operand source for each used field SHALL be selected in priority order: (1) a match with the dst of the instruction currently held in the output registers, when that instruction is a register write, causes a stall; (2) a match with ex_dst, when ex_reg_wr_vld && !ex_load_op, forwards ex_rslt; (3) a match with wb_addr when wb_en forwards wb_data; (4) a set pending bit causes a stall; (5) otherwise the register-file read value is used.
REQ-027 instr_rdy SHALL be the negation of the stall condition; it is combinational, and stall SHALL depend only on used source fields.
REQ-028 Register file: 8x8; the write port (wb_en/wb_addr/wb_data) SHALL be written on the rising edge, and the read ports SHALL be combinational.
REQ-029 All arithmetic and comparisons SHALL be unsigned; no width extension SHALL occur.

Reset
REQ-030 On rst, all outputs SHALL be 0 (opcode=nop) and the scoreboard SHALL be cleared, asynchronously.
REQ-031 Register-file contents SHALL be reset to 0.
REQ-032 If rst asserts mid-stall, the stalled instruction SHALL be dropped and fetch SHALL re-present it; instr_rdy SHALL be 1 after reset release.

Structure
REQ-033 Opcode constants (nop..st, 4-bit) and field positions SHALL reside in shared package risc_pkg, used by the decoder and the execution unit.
REQ-034 The register file SHALL be a sub-module, risc_regfile: one write port and two read ports.
REQ-035 Scoreboard, hazard detection and forwarding muxes SHALL reside in risc_decode.

Verification
REQ-036 Reset, then add r3,r1,r2 with r1=5, r2=7 already written -> next cycle opcode=0001, oprnd_a=5, oprnd_b=7, dst=3.
REQ-037 Back-to-back add r1,r2,r2 then sub r4,r1,r2 -> second held one cycle (instr_rdy=0, bubble issued), then issued with oprnd_a=ex_rslt.
REQ-038 ld r2,[0xA], then add r5,r2,r2 -> stall until wb_en/wb_addr=2 with wb_data=0x3C, then oprnd_a=oprnd_b=0x3C.
REQ-039 st r6,[0x4] with r6=0x81 -> opcode=1111, dmaddr=4, oprnd_a=0x81, no scoreboard bit set.
REQ-040 wb_en to r1 with wb_data=0x22 in the same cycle that an instruction reading r1 is accepted -> oprnd_a=0x22 (bypass).
REQ-041 Assert rst during a stall -> all outputs 0, scoreboard 0, instr_rdy=1 on the first cycle after release.
